// File: rtl/common_pkg.sv
// ---------------------------------------------------------------------------
// common_pkg
// Shared types and constants for the integer datapath blocks.
//   XLEN        : default operand / result width in bits
//   alu_op_t    : ALU operation encoding (divide ops plus ordinary ALU ops)
//   div_state_t : state encoding of the iterative divider FSM
// Helper functions classify an alu_op_t for the divider.
// ---------------------------------------------------------------------------
package common_pkg;

  localparam int XLEN = 32;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_SLL,
    ALU_SRL,
    ALU_SRA,
    ALU_SLT,
    ALU_SLTU,
    ALU_DIV,
    ALU_DIVU,
    ALU_REM,
    ALU_REMU
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } div_state_t;

  // True for the four operations the divider actually computes
  function automatic logic is_div_op(input alu_op_t op);
    return (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
  endfunction

  // Signed variants work on magnitudes and correct the sign afterwards
  function automatic logic is_signed_div(input alu_op_t op);
    return (op == ALU_DIV) || (op == ALU_REM);
  endfunction

  // Remainder variants return the partial remainder instead of the quotient
  function automatic logic is_rem_op(input alu_op_t op);
    return (op == ALU_REM) || (op == ALU_REMU);
  endfunction

endpackage

// File: rtl/div_step.sv
// ---------------------------------------------------------------------------
// div_step
// One restoring shift-subtract iteration, purely combinational.
// The partial remainder is shifted left by one with the next dividend bit
// appended; if the result is not smaller than the divisor it is reduced and
// the quotient bit is 1, otherwise it is kept and the quotient bit is 0.
// Ports:
//   i_rem          : partial remainder before this step
//   i_dividend_bit : next dividend bit (MSB first)
//   i_divisor      : divisor magnitude
//   o_rem          : partial remainder after this step
//   o_quot_bit     : quotient bit produced by this step
// ---------------------------------------------------------------------------
module div_step #(
  parameter int XLEN = common_pkg::XLEN
) (
  input  logic [XLEN-1:0] i_rem,
  input  logic            i_dividend_bit,
  input  logic [XLEN-1:0] i_divisor,
  output logic [XLEN-1:0] o_rem,
  output logic            o_quot_bit
);

  logic [XLEN:0]   w_shifted;
  logic [XLEN-1:0] w_diff;

  assign w_shifted  = {i_rem, i_dividend_bit};
  // The difference always fits in XLEN bits whenever it is selected, so only
  // the low bits of the subtraction are needed.
  assign w_diff     = w_shifted[XLEN-1:0] - i_divisor;
  // A zero divisor always "fits": quotient bits become all ones and the
  // remainder ends up equal to the dividend.
  assign o_quot_bit = (w_shifted >= {1'b0, i_divisor});
  assign o_rem      = o_quot_bit ? w_diff : w_shifted[XLEN-1:0];

endmodule

// File: rtl/div_sequencer.sv
// ---------------------------------------------------------------------------
// div_sequencer
// Iterative restoring divider for DIV / DIVU / REM / REMU.
// A request is latched in IDLE, XLEN shift-subtract steps run in CALC, FIX
// applies sign correction and selects quotient or remainder, and DONE holds
// the result until the consumer takes it.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid / in_ready   : request handshake (in_ready only in IDLE)
//   op                    : alu_op_t operation
//   operand_a / operand_b : dividend / divisor
//   flush                 : abort whatever is in flight, back to IDLE
//   out_valid / out_ready : result handshake
//   result                : quotient or remainder
// Build option:
//   DIV_SPECIAL_CASE_EN   : divide-by-zero and signed overflow skip the
//                           iteration and go straight to DONE.
// ---------------------------------------------------------------------------
module div_sequencer
  import common_pkg::*;
#(
  parameter int XLEN = common_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  alu_op_t         op,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  MIN_INT   = {1'b1, {(XLEN-1){1'b0}}};

  div_state_t       r_state;
  logic [CNT_W-1:0] r_count;
  alu_op_t          r_op;
  logic [XLEN-1:0]  r_dividend;
  logic [XLEN-1:0]  r_divisor;
  logic [XLEN-1:0]  r_quot;
  logic [XLEN-1:0]  r_rem;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_div_zero;
  logic             r_overflow;
  logic [XLEN-1:0]  r_result;

  logic             w_accept;
  logic             w_signed;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [XLEN-1:0]  w_abs_a;
  logic [XLEN-1:0]  w_abs_b;
  logic             w_div_zero;
  logic             w_overflow;
  logic [XLEN-1:0]  w_step_rem;
  logic             w_step_qbit;
  logic [XLEN-1:0]  w_quot_fixed;
  logic [XLEN-1:0]  w_rem_fixed;
  logic [XLEN-1:0]  w_fix_result;

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign result    = r_result;

  // Flush outranks a simultaneous request
  assign w_accept   = in_valid && in_ready && !flush;

  assign w_signed   = is_signed_div(op);
  assign w_a_neg    = w_signed && operand_a[XLEN-1];
  assign w_b_neg    = w_signed && operand_b[XLEN-1];
  // MIN_INT negates to itself, which is still its correct unsigned magnitude
  assign w_abs_a    = w_a_neg ? -operand_a : operand_a;
  assign w_abs_b    = w_b_neg ? -operand_b : operand_b;
  assign w_div_zero = (operand_b == '0);
  assign w_overflow = w_signed && (operand_a == MIN_INT) && (operand_b == '1);

  // The dividend magnitude sits in r_quot and is shifted out MSB first while
  // quotient bits are shifted in from the bottom.
  div_step #(
    .XLEN(XLEN)
  ) u_div_step (
    .i_rem          (r_rem),
    .i_dividend_bit (r_quot[XLEN-1]),
    .i_divisor      (r_divisor),
    .o_rem          (w_step_rem),
    .o_quot_bit     (w_step_qbit)
  );

  assign w_quot_fixed = r_neg_q ? -r_quot : r_quot;
  assign w_rem_fixed  = r_neg_r ? -r_rem : r_rem;

  // Divide-by-zero and overflow results are forced here because magnitude
  // arithmetic plus sign fix-up gets a negative dividend over zero wrong.
  always_comb begin
    w_fix_result = w_quot_fixed;
    if (r_div_zero) begin
      w_fix_result = is_rem_op(r_op) ? r_dividend : '1;
    end else if (r_overflow) begin
      w_fix_result = is_rem_op(r_op) ? '0 : MIN_INT;
    end else if (is_rem_op(r_op)) begin
      w_fix_result = w_rem_fixed;
    end
  end

`ifdef DIV_SPECIAL_CASE_EN
  logic [XLEN-1:0] w_special_result;

  // Result for the early-exit path, computed straight from the request
  always_comb begin
    w_special_result = is_rem_op(op) ? '0 : MIN_INT;
    if (w_div_zero) begin
      w_special_result = is_rem_op(op) ? operand_a : '1;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_count    <= '0;
      r_op       <= ALU_ADD;
      r_dividend <= '0;
      r_divisor  <= '0;
      r_quot     <= '0;
      r_rem      <= '0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_div_zero <= 1'b0;
      r_overflow <= 1'b0;
      r_result   <= '0;
    end else if (flush) begin
      r_state <= IDLE;
      r_count <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op       <= op;
            r_dividend <= operand_a;
            r_divisor  <= w_abs_b;
            r_quot     <= w_abs_a;
            r_rem      <= '0;
            r_neg_q    <= w_a_neg ^ w_b_neg;
            r_neg_r    <= w_a_neg;
            r_div_zero <= w_div_zero;
            r_overflow <= w_overflow;
            r_count    <= '0;
            if (!is_div_op(op)) begin
              r_result <= '0;
              r_state  <= DONE;
`ifdef DIV_SPECIAL_CASE_EN
            end else if (w_div_zero || w_overflow) begin
              r_result <= w_special_result;
              r_state  <= DONE;
`endif
            end else begin
              r_state <= CALC;
            end
          end
        end
        CALC: begin
          r_rem   <= w_step_rem;
          r_quot  <= {r_quot[XLEN-2:0], w_step_qbit};
          r_count <= r_count + CNT_W'(1);
          if (r_count == LAST_STEP) begin
            r_state <= FIX;
          end
        end
        FIX: begin
          r_result <= w_fix_result;
          r_state  <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// ---------------------------------------------------------------------------
// tb_div_sequencer
// Directed self-checking bench for div_sequencer with XLEN = 32.
// Expected results and latencies are hand-computed; the special-case
// latency depends on whether DIV_SPECIAL_CASE_EN is defined for the build.
// ---------------------------------------------------------------------------
module tb_div_sequencer;
  import common_pkg::*;

  localparam int LAT_NORM = 34;
`ifdef DIV_SPECIAL_CASE_EN
  localparam int LAT_SPECIAL = 1;
`else
  localparam int LAT_SPECIAL = 34;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  alu_op_t     op;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;

  int checks   = 0;
  int failures = 0;

  div_sequencer #(
    .XLEN(32)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  // 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something never returns
  initial begin
    #500000;
    $display("[TB] FAIL watchdog got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Presents one request (caller is just after a rising edge, block in IDLE)
  // and waits for out_valid; lat is the cycle count from accept, -1 on timeout
  task automatic applyStimulus(input alu_op_t opIn, input logic [31:0] aIn,
                               input logic [31:0] bIn, output int lat);
    op        = opIn;
    operand_a = aIn;
    operand_b = bIn;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) lat = -1;
  endtask

  // Full transaction: request, latency and result checks, then handshake
  task automatic runDiv(input string tag, input alu_op_t opIn, input logic [31:0] aIn,
                        input logic [31:0] bIn, input logic [31:0] expRes, input int expLat);
    int lat;
    applyStimulus(opIn, aIn, bIn, lat);
    checkOutput({tag, "_lat"}, 32'(lat), 32'(expLat));
    checkOutput({tag, "_res"}, result, expRes);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput({tag, "_idle"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int lat;
    int cyc;
    logic sawValid;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    op        = ALU_ADD;
    operand_a = '0;
    operand_b = '0;
    flush     = 1'b0;
    out_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_result", result, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic unsigned and signed quotients / remainders
    runDiv("divu_100_7", ALU_DIVU, 32'd100, 32'd7, 32'd14, LAT_NORM);
    runDiv("remu_100_7", ALU_REMU, 32'd100, 32'd7, 32'd2, LAT_NORM);
    runDiv("div_m7_2", ALU_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, LAT_NORM);
    runDiv("rem_m7_2", ALU_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, LAT_NORM);
    runDiv("div_7_m2", ALU_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, LAT_NORM);
    runDiv("rem_7_m2", ALU_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, LAT_NORM);
    runDiv("div_m7_m2", ALU_DIV, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, LAT_NORM);
    runDiv("rem_m7_m2", ALU_REM, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, LAT_NORM);

    // Non-divide op: zero result, one cycle
    runDiv("non_div_op", ALU_XOR, 32'd5, 32'd6, 32'd0, 1);

    // Divide by zero
    runDiv("div_5_0", ALU_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, LAT_SPECIAL);
    runDiv("rem_5_0", ALU_REM, 32'd5, 32'd0, 32'd5, LAT_SPECIAL);
    runDiv("divu_5_0", ALU_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, LAT_SPECIAL);
    runDiv("div_m5_0", ALU_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, LAT_SPECIAL);
    runDiv("rem_m5_0", ALU_REM, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, LAT_SPECIAL);

    // Signed overflow, and the same operands unsigned (not special)
    runDiv("div_ovf", ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_SPECIAL);
    runDiv("rem_ovf", ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, LAT_SPECIAL);
    runDiv("divu_big", ALU_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, LAT_NORM);
    runDiv("remu_big", ALU_REMU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_NORM);
    runDiv("divu_max_1", ALU_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, LAT_NORM);

    // Flush during cycle 10 of the operation
    sawValid  = 1'b0;
    op        = ALU_DIVU;
    operand_a = 32'd1000;
    operand_b = 32'd3;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 1;
    while (cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
      sawValid |= out_valid;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checkOutput("flush_idle", 32'(in_ready), 32'd1);
    checkOutput("flush_out_valid", 32'(out_valid), 32'd0);
    repeat (40) begin
      @(posedge clk); #1;
      sawValid |= out_valid;
    end
    checkOutput("flush_no_result", 32'(sawValid), 32'd0);
    runDiv("divu_9_3_after_flush", ALU_DIVU, 32'd9, 32'd3, 32'd3, LAT_NORM);

    // Back-pressure in DONE
    applyStimulus(ALU_DIVU, 32'd1000, 32'd7, lat);
    checkOutput("bp_lat", 32'(lat), 32'(LAT_NORM));
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_result_hold", result, 32'd142);
      checkOutput("bp_in_ready_low", 32'(in_ready), 32'd0);
      checkOutput("bp_out_valid_high", 32'(out_valid), 32'd1);
      @(posedge clk); #1;
    end
    // A request waiting during the handshake cycle must not be taken
    out_ready = 1'b1;
    op        = ALU_DIVU;
    operand_a = 32'd50;
    operand_b = 32'd5;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    checkOutput("bp_in_ready_after", 32'(in_ready), 32'd1);
    checkOutput("bp_out_valid_after", 32'(out_valid), 32'd0);

    // Flush wins over a simultaneous request in IDLE
    op        = ALU_DIVU;
    operand_a = 32'd8;
    operand_b = 32'd2;
    in_valid  = 1'b1;
    flush     = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    checkOutput("flush_beats_valid", 32'(in_ready), 32'd1);

    // Reset in the middle of an operation, after a nonzero result
    runDiv("divu_50_5", ALU_DIVU, 32'd50, 32'd5, 32'd10, LAT_NORM);
    op        = ALU_DIVU;
    operand_a = 32'd77;
    operand_b = 32'd7;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("midreset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midreset_result", result, 32'd0);
    #3;
    rst_n = 1'b1;
    sawValid = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      sawValid |= out_valid;
    end
    checkOutput("midreset_no_result", 32'(sawValid), 32'd0);
    runDiv("divu_77_7", ALU_DIVU, 32'd77, 32'd7, 32'd11, LAT_NORM);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
